// File: rtl/logic_capture_fifo_ram_param_dp.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// Storage is deliberately not reset.
module logic_capture_fifo_ram_param_dp #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/logic_capture_fifo_ram_param.sv
// RAM-backed capture FIFO: registered RAM read followed by an output/skid
// register, so the head word is held steady while the consumer stalls.
module logic_capture_fifo_ram_param #(
  parameter int WIDTH       = 32,
  parameter int ADDR_W      = 11,
  parameter int AFULL_LEVEL = (1 << ADDR_W) - 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WIDTH-1:0]  data_in_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [WIDTH-1:0]  data_out_o,
  output logic              accept_o,
  output logic              valid_o,
  output logic [ADDR_W:0]   level_o,
  output logic              almost_full_o,
  output logic              overflow_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0]  wr_ptr, rd_ptr, level;
  logic [WIDTH-1:0] ram_q, skid_data;
  logic             ram_vld, skid_vld, overflow;
  logic             full, empty, clear, advance, do_push, do_read;

  always_comb begin
    level   = wr_ptr - rd_ptr;
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
              (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    clear   = rst_i || flush_i;
    // The whole read pipeline moves only when the output slot is free or popped.
    advance = !skid_vld || pop_i;
    do_push = push_i && !full && !clear;
    do_read = !empty && advance && !clear;
  end

  logic_capture_fifo_ram_param_dp #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk_i),
    .wr_en   (do_push),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_data (data_in_i),
    .rd_en   (do_read),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk_i) begin
    if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_vld   <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_read) rd_ptr <= rd_ptr + PTR_ONE;
      if (push_i && full) overflow <= 1'b1;
      if (advance) begin
        ram_vld  <= do_read;
        skid_vld <= ram_vld;
        if (ram_vld) skid_data <= ram_q;
      end
    end
  end

  assign data_out_o    = skid_data;
  assign valid_o       = skid_vld;
  assign accept_o      = !full;
  assign level_o       = level;
  assign almost_full_o = (int'(level) >= AFULL_LEVEL);
  assign overflow_o    = overflow;

endmodule

// File: tb/tb_logic_capture_fifo_ram_param.sv
// Randomized and directed checks of the capture FIFO against a queue model.
module tb_logic_capture_fifo_ram_param;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int AFULL  = 5;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic [WIDTH-1:0]  data_in_i = '0;
  logic              push_i = 1'b0;
  logic              pop_i = 1'b0;
  logic              flush_i = 1'b0;
  logic [WIDTH-1:0]  data_out_o;
  logic              accept_o;
  logic              valid_o;
  logic [ADDR_W:0]   level_o;
  logic              almost_full_o;
  logic              overflow_o;

  logic_capture_fifo_ram_param #(
    .WIDTH       (WIDTH),
    .ADDR_W      (ADDR_W),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .data_in_i     (data_in_i),
    .push_i        (push_i),
    .pop_i         (pop_i),
    .flush_i       (flush_i),
    .data_out_o    (data_out_o),
    .accept_o      (accept_o),
    .valid_o       (valid_o),
    .level_o       (level_o),
    .almost_full_o (almost_full_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk = ~clk;

  int unsigned      n_checks = 0;
  int unsigned      n_pass   = 0;
  logic [WIDTH-1:0] model[$];
  logic             exp_ovf = 1'b0;
  logic             hold_pending = 1'b0;
  logic [WIDTH-1:0] hold_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: update the model from the inputs presented, then check after the edge.
  task automatic cycle();
    if (rst_i || flush_i) begin
      model.delete();
      exp_ovf      = 1'b0;
      hold_pending = 1'b0;
    end else begin
      if (push_i && accept_o) model.push_back(data_in_i);
      if (push_i && !accept_o) exp_ovf = 1'b1;
      if (pop_i && valid_o) begin
        if (model.size() == 0) check("pop_with_empty_model", 64'd1, 64'd0);
        else check("pop_data", 64'(data_out_o), 64'(model.pop_front()));
      end
      hold_pending = valid_o && !pop_i;
      hold_data    = data_out_o;
    end
    @(posedge clk);
    #1;
    check("overflow", 64'(overflow_o), 64'(exp_ovf));
    if (hold_pending) begin
      check("stall_valid", 64'(valid_o), 64'd1);
      check("stall_data", 64'(data_out_o), 64'(hold_data));
    end
  endtask

  task automatic idle_inputs();
    push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; rst_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    cycle();
    cycle();
    rst_i = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 64'(valid_o), 64'd0);
    check({tag, "_accept"}, 64'(accept_o), 64'd1);
    check({tag, "_level"}, 64'(level_o), 64'd0);
    check({tag, "_afull"}, 64'(almost_full_o), 64'd0);
    check({tag, "_data"}, 64'(data_out_o), 64'd0);
  endtask

  task automatic push_words(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      push_i = 1'b1;
      data_in_i = $urandom;
      cycle();
    end
    push_i = 1'b0;
  endtask

  task automatic drain();
    int unsigned budget = 4 * DEPTH + 20;
    push_i = 1'b0;
    pop_i  = 1'b1;
    while ((model.size() != 0 || valid_o) && budget != 0) begin
      cycle();
      budget--;
    end
    pop_i = 1'b0;
    check("drain_model_empty", 64'(model.size()), 64'd0);
    check("drain_valid", 64'(valid_o), 64'd0);
    check("drain_level", 64'(level_o), 64'd0);
  endtask

  initial begin
    // Reset values
    do_reset();
    check_cleared("reset");

    // Single word: valid two edges after the push, held while not popped
    push_i = 1'b1;
    data_in_i = 32'hA5A5_0001;
    cycle();
    push_i = 1'b0;
    cycle();
    check("single_valid_early", 64'(valid_o), 64'd0);
    cycle();
    check("single_valid", 64'(valid_o), 64'd1);
    check("single_data", 64'(data_out_o), 64'hA5A5_0001);
    check("single_level", 64'(level_o), 64'd0);
    for (int unsigned i = 0; i < 10; i++) cycle();
    check("single_hold_data", 64'(data_out_o), 64'hA5A5_0001);
    drain();

    // Fill: RAM holds DEPTH words plus two already staged towards the output
    do_reset();
    push_words(DEPTH + 2);
    check("full_accept", 64'(accept_o), 64'd0);
    check("full_level", 64'(level_o), 64'(DEPTH));
    push_i = 1'b1;
    data_in_i = 32'hDEAD_BEEF;
    cycle();
    push_i = 1'b0;
    check("drop_level", 64'(level_o), 64'(DEPTH));
    check("drop_model_size", 64'(model.size()), 64'(DEPTH + 2));
    drain();
    push_i = 1'b1; pop_i = 1'b1; flush_i = 1'b1;
    cycle();
    idle_inputs();
    check_cleared("flush_after_ovf");

    // Almost-full threshold, then flush with push/pop also asserted
    do_reset();
    push_words(AFULL - 1 + 2);
    cycle();
    cycle();
    check("afull_below_level", 64'(level_o), 64'(AFULL - 1));
    check("afull_below", 64'(almost_full_o), 64'd0);
    push_words(1);
    check("afull_at_level", 64'(level_o), 64'(AFULL));
    check("afull_at", 64'(almost_full_o), 64'd1);
    push_i = 1'b1; pop_i = 1'b1; flush_i = 1'b1;
    cycle();
    idle_inputs();
    check_cleared("flush");

    // Reset mid-stream with a stalled head word
    do_reset();
    push_words(5);
    cycle(); cycle(); cycle();
    check("mid_valid_pending", 64'(valid_o), 64'd1);
    rst_i = 1'b1; push_i = 1'b1; pop_i = 1'b1; flush_i = 1'b1;
    cycle();
    idle_inputs();
    check_cleared("mid_reset");
    push_i = 1'b1;
    data_in_i = 32'h1234_5678;
    cycle();
    push_i = 1'b0;
    cycle();
    cycle();
    check("post_reset_valid", 64'(valid_o), 64'd1);
    check("post_reset_data", 64'(data_out_o), 64'h1234_5678);
    drain();

    // Continuous streaming across pointer wrap
    do_reset();
    pop_i = 1'b1;
    for (int unsigned i = 0; i < 3 * DEPTH + 4; i++) begin
      push_i = 1'b1;
      data_in_i = WIDTH'(i);
      if (i >= 3) check("stream_gapless", 64'(valid_o), 64'd1);
      cycle();
    end
    push_i = 1'b0;
    drain();

    // Random traffic with random back-pressure
    do_reset();
    for (int unsigned i = 0; i < 10000; i++) begin
      push_i    = ($urandom_range(0, 99) < 55);
      pop_i     = $urandom_range(0, 1) == 1;
      data_in_i = $urandom;
      cycle();
      if (i % 256 == 0) check("rand_level_range", 64'(level_o <= DEPTH), 64'd1);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
